// File: rtl/lcd_capture_scaler.sv
// lcd_capture_scaler: captures an asynchronous LCD frame into a double-buffered RAM
// and replays it integer-upscaled with VGA timing.
module lcd_capture_scaler #(
  parameter int IN_W   = 160,
  parameter int IN_H   = 144,
  parameter int BPP    = 2,
  parameter int SCALE  = 4,
  parameter int H_FP   = 120,
  parameter int H_SYNC = 128,
  parameter int H_BP   = 168,
  parameter int V_FP   = 13,
  parameter int V_SYNC = 4,
  parameter int V_BP   = 35,
  parameter int FILT   = 2,
  parameter int INVERT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [BPP-1:0] idata,
  input  logic           iclk,
  input  logic           ihsync,
  input  logic           ivsync,
  output logic           hsync,
  output logic           vsync,
  output logic [BPP-1:0] r,
  output logic [BPP-1:0] g,
  output logic [BPP-1:0] b,
  output logic           frame_done,
  output logic           frame_err
);
  localparam int NPIX  = IN_W * IN_H;
  localparam int H_VIS = IN_W * SCALE;
  localparam int V_VIS = IN_H * SCALE;
  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOT);
  localparam int VW = $clog2(V_TOT);
  localparam int IW = $clog2(NPIX + 1);
  localparam int MW = $clog2(2 * NPIX);
  localparam int BW = $clog2(V_TOT * IN_W + 1);
  localparam int SW = $clog2(SCALE + 1);
  localparam int FW = $clog2(FILT + 1);

  logic [BPP-1:0] d_s1, d_s2, rdata;
  logic [2:0] c_s1, c_s2, flt, flt_q;
  logic fall, vrise, wr, full, done, swap, armed, wbank, pending;
  logic [IW-1:0] widx, widx_w;
  logic [MW-1:0] waddr, raddr;
  logic [HW-1:0] hcnt, hx;
  logic [VW-1:0] vcnt;
  logic [SW-1:0] hsub, vsub;
  logic [BW-1:0] vbase, lin;
  logic hend, vend, vis, hs, vs, vis_q, hs_q, vs_q;
  logic [BPP-1:0] mem [2*NPIX];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      d_s1  <= '0;
      d_s2  <= '0;
      c_s1  <= '0;
      c_s2  <= '0;
      flt_q <= '0;
    end else begin
      d_s1  <= idata;
      d_s2  <= d_s1;
      c_s1  <= {ivsync, ihsync, iclk};
      c_s2  <= c_s1;
      flt_q <= flt;
    end

  // bit 0 = iclk, bit 1 = ihsync, bit 2 = ivsync
  for (genvar i = 0; i < 3; i++) begin : g_flt
    logic [FW-1:0] cnt;
    logic st;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        cnt <= '0;
        st  <= 1'b0;
      end else if (c_s2[i] == st) cnt <= '0;
      else if (cnt == FW'(FILT - 1)) begin
        cnt <= '0;
        st  <= c_s2[i];
      end else cnt <= cnt + 1'b1;
    assign flt[i] = st;
  end

  assign fall   = flt_q[0] & ~flt[0];
  assign vrise  = ~flt_q[2] & flt[2];
  assign wr     = armed & fall & ~flt[1];
  assign full   = widx == IW'(NPIX);
  assign widx_w = widx + IW'(wr & ~full);
  assign done   = vrise & (widx_w == IW'(NPIX));
  assign swap   = pending & hend & vend;
  assign waddr  = MW'(widx) + (wbank ? MW'(NPIX) : '0);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      widx       <= '0;
      armed      <= 1'b0;
      wbank      <= 1'b0;
      pending    <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      widx       <= vrise ? '0 : widx_w;
      armed      <= armed | vrise;
      wbank      <= wbank ^ swap;
      pending    <= done | (pending & ~swap);
      frame_done <= done;
      frame_err  <= frame_err | (wr & full) | (vrise & (widx_w != '0) & (widx_w != IW'(NPIX)));
    end

  always_ff @(posedge clk) begin
    if (wr & ~full) mem[waddr] <= INVERT != 0 ? ~d_s2 : d_s2;
    rdata <= mem[raddr];
  end

  assign hend  = hcnt == HW'(H_TOT - 1);
  assign vend  = vcnt == VW'(V_TOT - 1);
  assign vis   = int'(hcnt) < H_VIS && int'(vcnt) < V_VIS;
  assign hs    = int'(hcnt) >= H_VIS + H_FP && int'(hcnt) < H_VIS + H_FP + H_SYNC;
  assign vs    = int'(vcnt) >= V_VIS + V_FP && int'(vcnt) < V_VIS + V_FP + V_SYNC;
  assign lin   = vbase + BW'(hx);
  assign raddr = (vis ? MW'(lin) : '0) + (wbank ? '0 : MW'(NPIX));

  // hsub/vsub track the position inside a SCALE x SCALE block so no divider is needed
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hcnt  <= '0;
      vcnt  <= '0;
      hsub  <= '0;
      vsub  <= '0;
      hx    <= '0;
      vbase <= '0;
    end else begin
      hcnt <= hend ? '0 : hcnt + 1'b1;
      hsub <= (hend || hsub == SW'(SCALE - 1)) ? '0 : hsub + 1'b1;
      hx   <= hend ? '0 : hx + HW'(hsub == SW'(SCALE - 1));
      if (hend) begin
        vcnt  <= vend ? '0 : vcnt + 1'b1;
        vsub  <= (vend || vsub == SW'(SCALE - 1)) ? '0 : vsub + 1'b1;
        vbase <= vend ? '0 : vbase + (vsub == SW'(SCALE - 1) ? BW'(IN_W) : '0);
      end
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vis_q <= 1'b0;
      hs_q  <= 1'b0;
      vs_q  <= 1'b0;
      hsync <= 1'b0;
      vsync <= 1'b0;
      r     <= '0;
    end else begin
      vis_q <= vis;
      hs_q  <= hs;
      vs_q  <= vs;
      hsync <= hs_q;
      vsync <= vs_q;
      r     <= vis_q ? rdata : '0;
    end

  assign g = r;
  assign b = r;
endmodule

// File: doc/lcd_capture_scaler.md
LCD_CAPTURE_SCALER -- requirements
Module: lcd_capture_scaler

Interface
REQ-001 Parameter IN_W, default 160: input pixels per line.
REQ-002 Parameter IN_H, default 144: input lines per frame.
REQ-003 Parameter BPP, default 2: bits per pixel; also the width of each colour output.
REQ-004 Parameter SCALE, default 4: integer upscale factor, applied identically horizontally and vertically; H_VIS = IN_W*SCALE, V_VIS = IN_H*SCALE.
REQ-005 Parameters H_FP, H_SYNC, H_BP, V_FP, V_SYNC, V_BP, defaults 120, 128, 168, 13, 4, 35: output porch and sync lengths, in pixel clocks and lines respectively.
REQ-006 Parameter FILT, default 2 (range 1..8): consecutive equal samples required to accept a level change on iclk, ihsync or ivsync.
REQ-007 Parameter INVERT, default 1: 1 = store ~idata, 0 = store idata.
REQ-008 clk  in  1  pixel/system clock; all logic is clocked on the rising edge.
REQ-009 rst_n  in  1  asynchronous, active-low reset.
REQ-010 idata  in  BPP  LCD pixel data, asynchronous to clk.
REQ-011 iclk, ihsync, ivsync  in  1 each  LCD pixel clock, line sync and frame sync, asynchronous to clk.
REQ-012 hsync, vsync  out  1 each  VGA syncs, active-high.
REQ-013 r, g, b  out  BPP each  greyscale pixel, identical on all three outputs.
REQ-014 frame_done  out  1  one-cycle pulse per accepted input frame.
REQ-015 frame_err  out  1  sticky flag: an input frame held more or fewer than IN_W*IN_H pixels.

Function
REQ-016 Each async input SHALL pass a 2-flop synchroniser, then the FILT-sample filter; the filtered state changes only after FILT consecutive equal synchronised samples that differ from the current state.
REQ-017 On each filtered iclk falling edge with filtered ihsync low, the block SHALL write the sampled (optionally inverted) idata at the current write index into the write bank, then increment the index.
REQ-018 When the write index reaches IN_W*IN_H, further writes in that frame SHALL be suppressed and frame_err SHALL be set.
REQ-019 On each filtered ivsync rising edge: if the index equals IN_W*IN_H, pulse frame_done and set pending; otherwise set frame_err, unless the index is 0 (first frame after reset). In both cases the index resets to 0.
REQ-020 A simultaneous ivsync rise and iclk fall SHALL perform the write first, then apply the index reset.
REQ-021 Storage: two banks of IN_W*IN_H x BPP bits each, one read port and one write port, both synchronous.
REQ-022 Output counters: hcnt wraps from H_VIS+H_FP+H_SYNC+H_BP-1 to 0; on each hcnt wrap, vcnt advances and wraps from V_VIS+V_FP+V_SYNC+V_BP-1 to 0.
REQ-023 Bank swap SHALL occur only when hcnt and vcnt both wrap to 0 and pending is set: the read bank takes the write bank, the write bank toggles, pending clears; the write index is unchanged.
REQ-024 A swap while an input frame is in progress SHALL NOT stall capture; the remainder of that frame goes to the new write bank.
REQ-025 A frame_done arriving in the same cycle as a swap SHALL set pending after the swap, so the completed frame is not lost.
REQ-026 Read address = (vcnt/SCALE)*IN_W + hcnt/SCALE while visible (hcnt<H_VIS, vcnt<V_VIS), otherwise 0; division by a power-of-two SCALE reduces to a shift, and other SCALE values use per-axis sub-counters, not dividers.
REQ-027 hsync is high for H_VIS+H_FP <= hcnt < H_VIS+H_FP+H_SYNC; vsync is defined the same way using the V parameters.
REQ-028 visible, hsync and vsync SHALL be delayed so that all outputs, including pixel data, appear exactly 2 clk after the counter value that produced them.
REQ-029 r, g, b SHALL be 0 whenever the delayed visible flag is 0.

Reset
REQ-030 While rst_n is low: hcnt=vcnt=0, write index 0, write bank 0, read bank 1, pending=0; hsync, vsync, r, g, b, frame_done and frame_err are 0; filter states low.
REQ-031 Memory contents are not reset; the first frame may show stale data until the first swap.
REQ-032 Reset asserted mid-frame SHALL abort capture; after release, capture resumes at the next filtered ivsync rise and output starts at hcnt=vcnt=0.

Verification
REQ-033 Full 160x144 input frame followed by an ivsync rise -> one frame_done pulse, frame_err=0, swap at the next output frame start, and pixel (x,y) appears on outputs for hcnt in [4x,4x+3] and vcnt in [4y,4y+3].
REQ-034 Frame of 23039 pixels -> frame_err=1, no frame_done, read bank unchanged.
REQ-035 Frame of 23041 pixels -> frame_err=1, the 23041st write is suppressed, and bank contents at indices 0..23039 are intact.
REQ-036 iclk glitch of FILT-1 clk cycles -> no write; glitch of FILT clk cycles -> exactly one write.
REQ-037 Timing check, defaults -> hsync high during hcnt 760..887, period 1056 clk; vsync high during vcnt 589..592, 628 lines; r=g=b=0 outside visible.
REQ-038 Two frames complete within one output frame -> one swap, to the newest bank; with SCALE=3, IN_W=8, IN_H=4 and custom timing -> address mapping holds.
